// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 (CPOL=0, CPHA=0, MSB-first) byte controller with
// host ready/valid byte interface and chip select held across multi-byte transfers.
`default_nettype none
`timescale 1ns/1ps

module spi_controller #(
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte,
  output logic       o_spi_clk,
  output logic       o_spi_copi,
  input  logic       i_spi_cipo,
  output logic       o_spi_cs_n
);

  localparam int            CW         = $clog2(CLKS_PER_HALF_BIT) + 1;
  localparam logic [CW-1:0] C_HALF_MAX = CW'(CLKS_PER_HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_XFER, ST_WAIT_NEXT, ST_CS_HOLD, ST_CS_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] half_cnt_q, half_cnt_d;
  logic [3:0]    edge_cnt_q, edge_cnt_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          last_q, last_d;
  logic          sclk_q, sclk_d;
  logic          copi_q, copi_d;
  logic          cs_n_q, cs_n_d;
  logic          rx_dv_q, rx_dv_d;
  logic          half_done;
  logic          accept;

  assign o_tx_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT_NEXT);
  assign half_done  = (half_cnt_q == C_HALF_MAX);
  assign accept     = i_tx_dv && o_tx_ready;

  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_done ? '0 : half_cnt_q + CW'(1);
    edge_cnt_d = edge_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    last_d     = last_q;
    sclk_d     = sclk_q;
    copi_d     = copi_q;
    cs_n_d     = cs_n_q;
    rx_dv_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_WAIT_NEXT: begin
        half_cnt_d = '0;
        if (accept) begin
          tx_shift_d = i_tx_byte;
          last_d     = i_tx_last;
          copi_d     = i_tx_byte[7];
          cs_n_d     = 1'b0;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (half_done) begin
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[6:0], i_spi_cipo};
          edge_cnt_d = 4'd0;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (half_done) begin
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (sclk_q) begin
            sclk_d = 1'b0;
            // edge_cnt_q holds the index of the previous edge; 14 means this is the 16th
            if (edge_cnt_q == 4'd14) begin
              rx_dv_d   = 1'b1;
              rx_byte_d = rx_shift_q;
              state_d   = last_q ? ST_CS_HOLD : ST_WAIT_NEXT;
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              copi_d     = tx_shift_q[6];
            end
          end else begin
            sclk_d     = 1'b1;
            rx_shift_d = {rx_shift_q[6:0], i_spi_cipo};
          end
        end
      end
      ST_CS_HOLD: begin
        if (half_done) begin
          cs_n_d  = 1'b1;
          state_d = ST_CS_GAP;
        end
      end
      ST_CS_GAP: begin
        if (half_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      half_cnt_q <= '0;
      edge_cnt_q <= 4'd0;
      tx_shift_q <= 8'h00;
      rx_shift_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      last_q     <= 1'b0;
      sclk_q     <= 1'b0;
      copi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_dv_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      last_q     <= last_d;
      sclk_q     <= sclk_d;
      copi_q     <= copi_d;
      cs_n_q     <= cs_n_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  assign o_rx_dv    = rx_dv_q;
  assign o_rx_byte  = rx_byte_q;
  assign o_spi_clk  = sclk_q;
  assign o_spi_copi = copi_q;
  assign o_spi_cs_n = cs_n_q;

endmodule

`default_nettype wire
